// File: rtl/btn_in_port.sv
// Debounced active-low pushbutton feeding the CPU IN path: synchronizes button and switches,
// captures the switch value on each clean press into a one-deep valid/ack holding register.
module btn_in_port #(
    parameter int DATA_WIDTH      = 16,
    parameter int SW_WIDTH        = 5,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  btn,
    input  logic [SW_WIDTH-1:0]   sw,
    input  logic                  in_ack,
    output logic                  in_valid,
    output logic [DATA_WIDTH-1:0] in_data,
    output logic                  overrun
);

    // Handshake: in_valid stays high until the CPU returns in_ack while in_valid=1;
    // in_ack seen while in_valid=0 is ignored. in_valid is the FULL state bit itself.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                  btn_meta_q;
    logic                  btn_s_q;
    logic [SW_WIDTH-1:0]   sw_meta_q;
    logic [SW_WIDTH-1:0]   sw_s_q;
    logic                  deb_q;
    logic                  deb_d;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  cnt_d;
    logic                  press;
    state_e                state_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q <= 1'b1;
            btn_s_q    <= 1'b1;
            sw_meta_q  <= '0;
            sw_s_q     <= '0;
        end else begin
            btn_meta_q <= btn;
            btn_s_q    <= btn_meta_q;
            sw_meta_q  <= sw;
            sw_s_q     <= sw_meta_q;
        end
    end

    // A differing sample must persist through the terminal count; any agreement restarts it.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        press = 1'b0;
        if (btn_s_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = btn_s_q;
                press = ~btn_s_q;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q <= 1'b1;
            cnt_q <= '0;
        end else begin
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (press) begin
                        data_q  <= DATA_WIDTH'(sw_s_q);
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (press) begin
                        // A same-edge ack frees the slot, so the new press is kept.
                        if (in_ack) begin
                            data_q    <= DATA_WIDTH'(sw_s_q);
                            overrun_q <= 1'b0;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else if (in_ack) begin
                        state_q   <= EMPTY;
                        overrun_q <= 1'b0;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign in_valid = (state_q == FULL);
    assign in_data  = data_q;
    assign overrun  = overrun_q;

endmodule
